ram_port_arbiter: RTL and testbench

- Shares the single-port matrix RAM (RAM_D words × DATA_W bits, synchronous read, 1-cycle latency) between two requesters.
- Requester H is the host loader: it writes the A/B operands and metadata words 0–1, and reads back C.
- Requester C is the matrix multiply control unit: it fetches operand blocks and writes back results.
- Ownership is round-robin with a bounded burst length; a lock input lets either side keep the port for an atomic sequence such as a writeback.

---
 rtl/ram_port_arbiter.sv | 149 ++++++++++++++
 tb/tb_ram_port_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter for the single-port matrix RAM: host loader (H) and
// multiply control unit (C), round-robin with bounded bursts and an owner lock.

// Per-requester beat acceptance and read-return tracking.
module ram_port_arbiter_side (
  input  logic clk,
  input  logic rst,
  input  logic gnt,
  input  logic req,
  input  logic we,
  output logic acc,
  output logic rvalid
);

  assign acc = gnt & req;

  // RAM read latency is one cycle, so a read beat's data lands next cycle
  // regardless of who owns the port by then.
  always_ff @(posedge clk) begin
    if (rst) rvalid <= 1'b0;
    else     rvalid <= acc & ~we;
  end

endmodule

module ram_port_arbiter #(
  parameter int DATA_W    = 32,
  parameter int RAM_D     = 512,
  parameter int ADDR_W    = $clog2(RAM_D),
  parameter int MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              h_req,
  input  logic              h_lock,
  input  logic              h_we,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [DATA_W-1:0] h_wdata,
  output logic              h_gnt,
  output logic              h_rvalid,
  output logic [DATA_W-1:0] h_rdata,
  input  logic              c_req,
  input  logic              c_lock,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_w_data,
  input  logic [DATA_W-1:0] ram_r_data,
  output logic [7:0]        beat_cnt
);

  localparam int         NUM_SIDES = 2;
  localparam logic [1:0] OWN_NONE  = 2'd0;
  localparam logic [1:0] OWN_H     = 2'd1;
  localparam logic [1:0] OWN_C     = 2'd2;
  localparam logic [7:0] BURST_LIM = 8'(MAX_BURST);

  // Side index 0 = host, 1 = control unit.
  logic [NUM_SIDES-1:0]             req_v, lock_v, we_v, gnt_v, acc_v, rvalid_v;
  logic [NUM_SIDES-1:0][ADDR_W-1:0] addr_v;
  logic [NUM_SIDES-1:0][DATA_W-1:0] wdata_v;

  logic [1:0]        owner, owner_nxt, own_other;
  logic              last_c, own_c, sel, any_acc;
  logic [7:0]        cnt_inc;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  assign req_v   = {c_req,   h_req};
  assign lock_v  = {c_lock,  h_lock};
  assign we_v    = {c_we,    h_we};
  assign addr_v  = {c_addr,  h_addr};
  assign wdata_v = {c_wdata, h_wdata};
  assign gnt_v   = {owner == OWN_C, owner == OWN_H};

  for (genvar i = 0; i < NUM_SIDES; i++) begin : g_side
    ram_port_arbiter_side u_side (
      .clk    (clk),
      .rst    (rst),
      .gnt    (gnt_v[i]),
      .req    (req_v[i]),
      .we     (we_v[i]),
      .acc    (acc_v[i]),
      .rvalid (rvalid_v[i])
    );
  end

  assign h_gnt    = gnt_v[0];
  assign c_gnt    = gnt_v[1];
  assign h_rvalid = rvalid_v[0];
  assign c_rvalid = rvalid_v[1];
  assign h_rdata  = ram_r_data;
  assign c_rdata  = ram_r_data;

  // At most one side holds the grant, so the accepting side selects the mux.
  assign any_acc    = |acc_v;
  assign sel        = acc_v[1];
  assign ram_we     = any_acc & we_v[sel] & ~rst;
  assign ram_addr   = any_acc ? addr_v[sel]  : addr_q;
  assign ram_w_data = any_acc ? wdata_v[sel] : wdata_q;

  always_ff @(posedge clk) begin
    if (any_acc) begin
      addr_q  <= addr_v[sel];
      wdata_q <= wdata_v[sel];
    end
  end

  assign cnt_inc   = (any_acc && beat_cnt != 8'hFF) ? beat_cnt + 8'd1 : beat_cnt;
  assign own_c     = (owner == OWN_C);
  assign own_other = own_c ? OWN_H : OWN_C;

  always_comb begin
    owner_nxt = owner;
    if (owner == OWN_NONE) begin
      if (h_req && (!c_req || last_c)) owner_nxt = OWN_H;
      else if (c_req)                  owner_nxt = OWN_C;
    end else if (owner != OWN_H && owner != OWN_C) begin
      owner_nxt = OWN_NONE;
    end else if (!req_v[own_c]) begin
      owner_nxt = req_v[!own_c] ? own_other : OWN_NONE;
    end else if (!lock_v[own_c] && cnt_inc >= BURST_LIM && req_v[!own_c]) begin
      // The count includes this cycle's beat so the handover costs no bubble.
      owner_nxt = own_other;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner    <= OWN_NONE;
      last_c   <= 1'b1;
      beat_cnt <= 8'd0;
    end else begin
      owner <= owner_nxt;
      if (owner_nxt != owner) begin
        beat_cnt <= 8'd0;
        if (owner != OWN_NONE) last_c <= own_c;
      end else begin
        beat_cnt <= cnt_inc;
      end
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed + random bench for ram_port_arbiter against an ownership/RAM model.
module tb_ram_port_arbiter;

  localparam int DW = 32;
  localparam int RD = 512;
  localparam int AW = 9;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          h_req, h_lock, h_we, c_req, c_lock, c_we;
  logic [AW-1:0] h_addr, c_addr;
  logic [DW-1:0] h_wdata, c_wdata;
  logic          h_gnt, h_rvalid, c_gnt, c_rvalid, ram_we;
  logic [DW-1:0] h_rdata, c_rdata, ram_w_data, ram_r_data;
  logic [AW-1:0] ram_addr;
  logic [7:0]    beat_cnt;

  int vectors = 0;
  int miscompares = 0;

  ram_port_arbiter #(.DATA_W(DW), .RAM_D(RD), .ADDR_W(AW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .h_req(h_req), .h_lock(h_lock), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
    .c_req(c_req), .c_lock(c_lock), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_w_data(ram_w_data),
    .ram_r_data(ram_r_data), .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] seed_word(input int i);
    return (i * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  // Behavioural single-port RAM, synchronous read, 1-cycle latency.
  logic [DW-1:0] mem [RD];
  logic          ram_init = 1'b1;
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < RD; i++) mem[i] <= seed_word(i);
    end else begin
      if (ram_we) mem[ram_addr] <= ram_w_data;
      ram_r_data <= mem[ram_addr];
    end
  end

  // Reference model: owner 0 = none, 1 = host, 2 = control unit.
  logic [DW-1:0] mdl_mem [RD];
  int            m_own = 0;
  int            m_cnt = 0;
  bit            m_last_c = 1'b1;
  bit            m_hrv = 1'b0, m_crv = 1'b0, m_have = 1'b0;
  logic [DW-1:0] m_hrd, m_crd, m_ld;
  logic [AW-1:0] m_la;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bit acc_h, acc_c, acc, my_req, my_lock, oth_req;
    int cnt_now, nxt;
    @(negedge clk);
    acc_h = (m_own == 1) && h_req;
    acc_c = (m_own == 2) && c_req;
    acc   = acc_h || acc_c;
    chk("h_gnt", 32'(h_gnt), 32'(m_own == 1));
    chk("c_gnt", 32'(c_gnt), 32'(m_own == 2));
    chk("ram_we", 32'(ram_we), 32'(acc && !rst && (acc_h ? h_we : c_we)));
    if (acc) begin
      m_la   = acc_h ? h_addr  : c_addr;
      m_ld   = acc_h ? h_wdata : c_wdata;
      m_have = 1'b1;
    end
    if (m_have) begin
      chk("ram_addr", 32'(ram_addr), 32'(m_la));
      chk("ram_w_data", ram_w_data, m_ld);
    end
    chk("h_rvalid", 32'(h_rvalid), 32'(m_hrv));
    chk("c_rvalid", 32'(c_rvalid), 32'(m_crv));
    if (m_hrv) chk("h_rdata", h_rdata, m_hrd);
    if (m_crv) chk("c_rdata", c_rdata, m_crd);
    chk("beat_cnt", 32'(beat_cnt), 32'(m_cnt));

    if (rst) begin
      m_own = 0; m_cnt = 0; m_last_c = 1'b1; m_hrv = 1'b0; m_crv = 1'b0;
    end else begin
      m_hrv = acc_h && !h_we;
      m_crv = acc_c && !c_we;
      if (acc_h) m_hrd = mdl_mem[h_addr];
      if (acc_c) m_crd = mdl_mem[c_addr];
      if (acc_h && h_we) mdl_mem[h_addr] = h_wdata;
      if (acc_c && c_we) mdl_mem[c_addr] = c_wdata;
      cnt_now = acc ? ((m_cnt + 1 > 255) ? 255 : m_cnt + 1) : m_cnt;
      if (m_own == 0) begin
        if (h_req && c_req) nxt = m_last_c ? 1 : 2;
        else if (h_req)     nxt = 1;
        else if (c_req)     nxt = 2;
        else                nxt = 0;
      end else begin
        my_req  = (m_own == 1) ? h_req  : c_req;
        my_lock = (m_own == 1) ? h_lock : c_lock;
        oth_req = (m_own == 1) ? c_req  : h_req;
        if (!my_req)                                  nxt = oth_req ? 3 - m_own : 0;
        else if (!my_lock && cnt_now >= MB && oth_req) nxt = 3 - m_own;
        else                                           nxt = m_own;
      end
      if (nxt != m_own) begin
        if (m_own != 0) m_last_c = (m_own == 2);
        m_cnt = 0;
      end else begin
        m_cnt = cnt_now;
      end
      m_own = nxt;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    h_req = 0; h_lock = 0; h_we = 0; h_addr = '0; h_wdata = '0;
    c_req = 0; c_lock = 0; c_we = 0; c_addr = '0; c_wdata = '0;
  endtask

  initial begin
    int k, guard;
    logic [AW-1:0] wa;
    for (int i = 0; i < RD; i++) mdl_mem[i] = seed_word(i);
    idle_inputs();
    rst = 1;
    @(posedge clk); #1;
    ram_init = 1'b0;
    tick(); tick();
    rst = 0;

    // First host write: one idle cycle, then the beat.
    h_req = 1; h_we = 1; h_addr = '0; h_wdata = 32'h02030304;
    tick(); tick();
    h_req = 0; tick();

    // Host writes 5, releases; C reads it back.
    h_req = 1; h_we = 1; h_addr = 9'd5; h_wdata = 32'hDEADBEEF;
    tick(); tick();
    h_req = 0; tick();
    c_req = 1; c_we = 0; c_addr = 9'd5;
    tick(); tick();
    c_req = 0; tick(); tick();

    // Both streaming, unlocked: MB-beat alternation.
    h_req = 1; c_req = 1;
    for (int i = 0; i < 20; i++) begin
      h_we = 1'($urandom); c_we = 1'($urandom);
      h_addr = AW'($urandom); c_addr = AW'($urandom);
      h_wdata = $urandom; c_wdata = $urandom;
      tick();
    end
    idle_inputs(); tick(); tick();

    // Locked C burst of 20 writes with H waiting.
    c_req = 1; c_lock = 1; c_we = 1;
    k = 0; guard = 0;
    h_req = 1; h_we = 0;
    while (k < 20 && guard < 60) begin
      bit pred;
      c_addr = AW'(511 - k); c_wdata = $urandom;
      pred = (m_own == 2);
      tick();
      if (pred) k++;
      guard++;
    end
    chk("lock_stream_done", 32'(k), 32'd20);
    c_req = 0; c_lock = 0;
    tick(); tick();
    idle_inputs(); tick();

    // Read 511 then the wrapped address 0.
    c_req = 1; c_we = 0; wa = 9'd511; c_addr = wa;
    k = 0; guard = 0;
    while (k < 2 && guard < 10) begin
      bit pred;
      pred = (m_own == 2);
      tick();
      if (pred) begin k++; wa = wa + 1'b1; c_addr = wa; end
      guard++;
    end
    chk("wrap_reads_done", 32'(k), 32'd2);
    c_req = 0; tick(); tick();

    // Reset mid-burst with a write pending.
    h_req = 1; h_we = 1; h_addr = 9'd77; h_wdata = 32'hCAFEF00D;
    tick(); tick();
    rst = 1; tick();
    rst = 0; c_req = 1; c_we = 1; c_addr = 9'd88; c_wdata = 32'h12345678;
    tick(); tick(); tick();
    idle_inputs(); tick();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      h_req = ($urandom_range(3) != 0); c_req = ($urandom_range(3) != 0);
      h_lock = ($urandom_range(7) == 0); c_lock = ($urandom_range(7) == 0);
      h_we = 1'($urandom); c_we = 1'($urandom);
      h_addr = AW'($urandom); c_addr = AW'($urandom);
      h_wdata = $urandom; c_wdata = $urandom;
      rst = ($urandom_range(99) == 0);
      tick();
    end
    rst = 0; idle_inputs(); tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
